ps2_rx_chk: RTL and testbench

//  PS/2 device-to-host frame receiver with parity/framing check and a bus-stall timeout.

---
 rtl/ps2_rx_chk.sv | 144 ++++++++++++++
 tb/tb_ps2_rx_chk.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_chk.sv
// ---------------------------------------------------------------------------
// ps2_rx_chk
//   PS/2 device-to-host frame receiver. Glitch-filters the PS/2 clock, shifts
//   in start + 8 data bits (LSB first) + odd parity + stop on filtered falling
//   edges, flags parity and framing errors, and aborts a frame whose clock
//   stalls for longer than TIMEOUT cycles. rx_idle_o tells the companion
//   host-side transmitter when no frame is in flight.
//
// Ports
//   clk_i           system clock
//   reset_i         synchronous, active-high reset
//   rx_en_i         permits a new frame to start (only looked at in IDLE)
//   ps2d_i          PS/2 data pin, read side
//   ps2c_i          PS/2 clock pin, read side
//   rx_idle_o       1 while the receiver FSM is in IDLE
//   rx_done_tick_o  one-cycle pulse when a frame completes
//   dout_o          last received byte, held until the next completion
//   par_err_o       odd-parity failure of the last completed frame
//   frm_err_o       bad start or stop bit in the last completed frame
//   to_tick_o       one-cycle pulse when a frame is aborted by timeout
//
// state | meaning
// IDLE  | waiting for a start-bit falling edge while rx_en_i is high
// DPS   | shifting data, parity and stop bits; stall timer running
// LOAD  | frame complete, rx_done_tick_o high for this one cycle
// ---------------------------------------------------------------------------
module ps2_rx_chk #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       rx_en_i,
  input  logic       ps2d_i,
  input  logic       ps2c_i,
  output logic       rx_idle_o,
  output logic       rx_done_tick_o,
  output logic [7:0] dout_o,
  output logic       par_err_o,
  output logic       frm_err_o,
  output logic       to_tick_o
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TERM = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, DPS, LOAD} state_t;

  logic [FILTER_LEN-1:0] filter_q, filter_d;
  logic                  f_ps2c_q, f_ps2c_d;
  logic                  fall_edge;

  state_t                state_q;
  logic [3:0]            n_q;
  logic [10:0]           b_q, b_d;
  logic [TW-1:0]         timer_q;
  logic [7:0]            dout_q;
  logic                  par_err_q;
  logic                  frm_err_q;
  logic                  done_q;

  // Filtered clock only changes once the whole window agrees, so short
  // glitches are absorbed by the hold branch.
  always_comb begin
    filter_d = {ps2c_i, filter_q[FILTER_LEN-1:1]};
    if (&filter_d)
      f_ps2c_d = 1'b1;
    else if (~|filter_d)
      f_ps2c_d = 1'b0;
    else
      f_ps2c_d = f_ps2c_q;
  end

  assign fall_edge = f_ps2c_q & ~f_ps2c_d;
  assign b_d       = {ps2d_i, b_q[10:1]};

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      filter_q <= '0;
      f_ps2c_q <= 1'b0;
    end else begin
      filter_q <= filter_d;
      f_ps2c_q <= f_ps2c_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      n_q       <= '0;
      b_q       <= '0;
      timer_q   <= '0;
      dout_q    <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (fall_edge && rx_en_i) begin
            b_q     <= b_d;
            n_q     <= 4'd9;
            timer_q <= '0;
            state_q <= DPS;
          end
        end
        DPS: begin
          // An edge in the terminal cycle wins over the timeout.
          if (fall_edge) begin
            b_q     <= b_d;
            timer_q <= '0;
            if (n_q == 4'd0) begin
              // b_d is the complete frame: [0] start, [8:1] data,
              // [9] parity, [10] stop.
              state_q   <= LOAD;
              dout_q    <= b_d[8:1];
              par_err_q <= ~(^b_d[9:1]);
              frm_err_q <= b_d[0] | ~b_d[10];
              done_q    <= 1'b1;
            end else begin
              n_q <= n_q - 4'd1;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
            if (timer_q == TERM)
              state_q <= IDLE;
          end
        end
        LOAD: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Timeout pulse coincides with the cycle the timer hits terminal count.
  assign to_tick_o      = (state_q == DPS) && !fall_edge && (timer_q == TERM);
  assign rx_idle_o      = (state_q == IDLE);
  assign rx_done_tick_o = done_q;
  assign dout_o         = dout_q;
  assign par_err_o      = par_err_q;
  assign frm_err_o      = frm_err_q;

endmodule

// File: tb/tb_ps2_rx_chk.sv
module tb_ps2_rx_chk;

  localparam int FL = 8;
  localparam int TO = 3000;

  logic       clk = 1'b0;
  logic       reset, rx_en, ps2d, ps2c;
  logic       rx_idle, rx_done_tick, par_err, frm_err, to_tick;
  logic [7:0] dout;

  ps2_rx_chk #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .rx_en_i        (rx_en),
    .ps2d_i         (ps2d),
    .ps2c_i         (ps2c),
    .rx_idle_o      (rx_idle),
    .rx_done_tick_o (rx_done_tick),
    .dout_o         (dout),
    .par_err_o      (par_err),
    .frm_err_o      (frm_err),
    .to_tick_o      (to_tick)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  int         done_cnt = 0;
  int         to_cnt   = 0;
  int         both_cnt = 0;
  logic       busy_seen = 1'b0;
  logic [7:0] cap_dout;
  logic       cap_par, cap_frm, cap_idle;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(posedge clk) begin
    #1;
    if (rx_done_tick) begin
      done_cnt++;
      cap_dout = dout;
      cap_par  = par_err;
      cap_frm  = frm_err;
      cap_idle = rx_idle;
    end
    if (to_tick) to_cnt++;
    if (rx_done_tick && to_tick) both_cnt++;
    if (!rx_idle) busy_seen = 1'b1;
  end

  // Sends bits f[0..nb-1]; data set during the high half, sampled in the low half.
  task automatic send_bits(input logic [10:0] f, input int nb, input int half);
    for (int i = 0; i < nb; i++) begin
      @(negedge clk) ps2d = f[i];
      repeat (half) @(negedge clk);
      ps2c = 1'b0;
      repeat (half) @(negedge clk);
      ps2c = 1'b1;
    end
  endtask

  function automatic logic [10:0] mk(input logic [7:0] d, input logic p, input logic s);
    return {s, p, d, 1'b0};
  endfunction

  initial begin
    int n;
    int d0;
    reset = 1'b1; rx_en = 1'b1; ps2d = 1'b1; ps2c = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_idle", rx_idle, 1);
    chk("rst_dout", dout, 8'h00);
    chk("rst_par",  par_err, 0);
    chk("rst_frm",  frm_err, 0);
    chk("rst_done", rx_done_tick, 0);
    repeat (3 * FL) @(negedge clk);

    // 1: clean 0x1C, slow bit period
    busy_seen = 1'b0;
    send_bits(mk(8'h1C, 1'b0, 1'b1), 1, 1000);
    chk("t1_busy_after_start", rx_idle, 0);
    send_bits(mk(8'h1C, 1'b0, 1'b1) >> 1, 10, 1000);
    repeat (50) @(negedge clk);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_dout", cap_dout, 8'h1C);
    chk("t1_par", cap_par, 0);
    chk("t1_frm", cap_frm, 0);
    chk("t1_idle_at_tick", cap_idle, 0);
    chk("t1_idle_after", rx_idle, 1);
    chk("t1_to_cnt", to_cnt, 0);

    // 2: parity error
    send_bits(mk(8'h1C, 1'b1, 1'b1), 11, 50);
    repeat (50) @(negedge clk);
    chk("t2_done_cnt", done_cnt, 2);
    chk("t2_dout", cap_dout, 8'h1C);
    chk("t2_par", cap_par, 1);
    chk("t2_frm", cap_frm, 0);

    // 3: stop bit 0
    send_bits(mk(8'hF0, 1'b1, 1'b0), 11, 50);
    repeat (50) @(negedge clk);
    chk("t3_done_cnt", done_cnt, 3);
    chk("t3_dout", cap_dout, 8'hF0);
    chk("t3_frm", cap_frm, 1);
    chk("t3_par", cap_par, 0);

    // 4: short glitch in IDLE
    busy_seen = 1'b0;
    @(negedge clk) ps2c = 1'b0;
    repeat (FL - 3) @(negedge clk);
    ps2c = 1'b1;
    repeat (3 * FL) @(negedge clk);
    chk("t4_busy", busy_seen, 0);
    chk("t4_done_cnt", done_cnt, 3);
    chk("t4_to_cnt", to_cnt, 0);

    // 5: stall after 4 data bits -> timeout, then a clean frame
    send_bits(mk(8'h55, 1'b1, 1'b1), 4, 50);
    @(negedge clk) ps2d = 1'b1;
    repeat (50) @(negedge clk);
    ps2c = 1'b0;
    n = 0;
    while (n < FL + TO + 50) begin
      @(posedge clk); #1;
      n++;
      if (n == 50) ps2c = 1'b1;
      if (to_tick) break;
    end
    chk("t5_to_latency", n, FL + TO - 1);
    @(posedge clk); #1;
    chk("t5_to_pulse_width", to_tick, 0);
    chk("t5_idle", rx_idle, 1);
    chk("t5_to_cnt", to_cnt, 1);
    chk("t5_done_cnt", done_cnt, 3);
    chk("t5_dout_held", dout, 8'hF0);
    chk("t5_frm_held", frm_err, 1);
    repeat (20) @(negedge clk);
    send_bits(mk(8'hAA, 1'b1, 1'b1), 11, 50);
    repeat (50) @(negedge clk);
    chk("t5b_done_cnt", done_cnt, 4);
    chk("t5b_dout", cap_dout, 8'hAA);
    chk("t5b_par", cap_par, 0);
    chk("t5b_frm", cap_frm, 0);

    // 6: rx_en low ignores a frame; reset mid-frame clears everything
    busy_seen = 1'b0;
    rx_en = 1'b0;
    send_bits(mk(8'h3C, 1'b1, 1'b1), 11, 50);
    repeat (50) @(negedge clk);
    chk("t6_ignored_busy", busy_seen, 0);
    chk("t6_ignored_done", done_cnt, 4);
    rx_en = 1'b1;
    send_bits(mk(8'h3C, 1'b1, 1'b1), 4, 50);
    chk("t6_busy_mid", rx_idle, 0);
    d0 = done_cnt;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("t6_rst_idle", rx_idle, 1);
    chk("t6_rst_dout", dout, 8'h00);
    chk("t6_rst_par", par_err, 0);
    chk("t6_rst_frm", frm_err, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4 * FL) @(negedge clk);
    chk("t6_no_done", done_cnt, d0);
    chk("t6_no_to", to_cnt, 1);
    chk("never_both_ticks", both_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
